// File: rtl/data_write_sink.sv
// data_write_sink: receiving end of the data-cache data-array write path.
// Buffers arbitrated 128-bit write requests in a 2-entry FIFO and drains each
// entry onto a 64-bit single-ported SRAM write port, one half per cycle.
// Array reads (io_rd_valid) own the SRAM port and stall draining.
//
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   io_in_*            : valid/ready write request {way_en, addr, wmask, data}
//   io_rd_valid        : array read holds the SRAM port this cycle
//   io_sram_*          : SRAM write strobe, way enable, {row, half} address, data
//   io_count, io_busy  : FIFO occupancy and non-empty flag
module data_write_sink (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [7:0]   io_in_bits_way_en,
  input  logic [11:0]  io_in_bits_addr,
  input  logic [1:0]   io_in_bits_wmask,
  input  logic [127:0] io_in_bits_data,
  input  logic         io_rd_valid,
  output logic         io_sram_wen,
  output logic [7:0]   io_sram_way_en,
  output logic [12:0]  io_sram_addr,
  output logic [63:0]  io_sram_wdata,
  output logic [1:0]   io_count,
  output logic         io_busy
);

  logic [7:0]   way_q   [2];
  logic [11:0]  addr_q  [2];
  logic [1:0]   wmask_q [2];
  logic [127:0] data_q  [2];

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       beat_q, beat_d;

  logic       push, pop, drain, empty, half;
  logic [1:0] hd_mask;

  assign empty       = (count_q == 2'd0);
  assign io_in_ready = (count_q != 2'd2);
  assign push        = io_in_valid && io_in_ready;
  assign drain       = !empty && !io_rd_valid;
  assign hd_mask     = wmask_q[head_q];

  always_comb begin
    half   = 1'b0;
    pop    = 1'b0;
    beat_d = beat_q;
    case (hd_mask)
      2'b01: begin
        half = 1'b0;
        pop  = drain;
      end
      2'b10: begin
        half = 1'b1;
        pop  = drain;
      end
      2'b11: begin
        half = beat_q;
        pop  = drain && beat_q;
        if (drain) beat_d = ~beat_q;
      end
      default: begin
        // Empty mask: retire the entry in one cycle without writing.
        half = 1'b0;
        pop  = drain;
      end
    endcase
  end

  always_comb begin
    head_d  = pop  ? ~head_q : head_q;
    tail_d  = push ? ~tail_q : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The reset cycle must never issue a write, even with stale entries queued.
  assign io_sram_wen    = drain && (hd_mask != 2'b00) && !reset;
  assign io_sram_way_en = empty ? 8'd0  : way_q[head_q];
  assign io_sram_addr   = empty ? 13'd0 : {addr_q[head_q], half};
  assign io_sram_wdata  = empty ? 64'd0 :
                          (half ? data_q[head_q][127:64] : data_q[head_q][63:0]);
  assign io_count       = count_q;
  assign io_busy        = !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      beat_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (push) begin
      way_q[tail_q]   <= io_in_bits_way_en;
      addr_q[tail_q]  <= io_in_bits_addr;
      wmask_q[tail_q] <= io_in_bits_wmask;
      data_q[tail_q]  <= io_in_bits_data;
    end
  end

endmodule

// File: tb/tb_data_write_sink.sv
module tb_data_write_sink;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [7:0]   io_in_bits_way_en;
  logic [11:0]  io_in_bits_addr;
  logic [1:0]   io_in_bits_wmask;
  logic [127:0] io_in_bits_data;
  logic         io_rd_valid;
  logic         io_sram_wen;
  logic [7:0]   io_sram_way_en;
  logic [12:0]  io_sram_addr;
  logic [63:0]  io_sram_wdata;
  logic [1:0]   io_count;
  logic         io_busy;

  data_write_sink dut (
    .clock             (clock),
    .reset             (reset),
    .io_in_valid       (io_in_valid),
    .io_in_ready       (io_in_ready),
    .io_in_bits_way_en (io_in_bits_way_en),
    .io_in_bits_addr   (io_in_bits_addr),
    .io_in_bits_wmask  (io_in_bits_wmask),
    .io_in_bits_data   (io_in_bits_data),
    .io_rd_valid       (io_rd_valid),
    .io_sram_wen       (io_sram_wen),
    .io_sram_way_en    (io_sram_way_en),
    .io_sram_addr      (io_sram_addr),
    .io_sram_wdata     (io_sram_wdata),
    .io_count          (io_count),
    .io_busy           (io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  way;
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  // A buffered request: its mask and how many unstalled cycles it still needs.
  typedef struct {
    logic [1:0] mask;
    int         left;
  } ent_t;

  wr_t  sb[$];
  ent_t mq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on the clock edge from the inputs held that cycle.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      sb.delete();
    end else begin
      int   sz;
      logic acc;
      sz  = mq.size();
      acc = io_in_valid && (sz < 2);
      if (!io_rd_valid && sz > 0) begin
        if (mq[0].left > 1) mq[0].left = mq[0].left - 1;
        else void'(mq.pop_front());
      end
      if (acc) begin
        ent_t e;
        e.mask = io_in_bits_wmask;
        e.left = (io_in_bits_wmask == 2'b11) ? 2 : 1;
        mq.push_back(e);
        if (io_in_bits_wmask[0])
          sb.push_back('{io_in_bits_way_en, {io_in_bits_addr, 1'b0}, io_in_bits_data[63:0]});
        if (io_in_bits_wmask[1])
          sb.push_back('{io_in_bits_way_en, {io_in_bits_addr, 1'b1}, io_in_bits_data[127:64]});
      end
    end
  end

  // Monitor: samples away from the active edge.
  always @(negedge clock) begin
    logic exp_wen;
    int   sz;
    sz = mq.size();
    exp_wen = !reset && sz > 0 && !io_rd_valid && (mq[0].mask != 2'b00);
    check("wen", 64'(io_sram_wen), 64'(exp_wen));
    if (io_sram_wen && exp_wen) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("way_en", 64'(io_sram_way_en), 64'(w.way));
        check("addr", 64'(io_sram_addr), 64'(w.addr));
        check("wdata", io_sram_wdata, w.data);
      end
    end
    check("count", 64'(io_count), 64'(sz));
    check("ready", 64'(io_in_ready), 64'(sz < 2));
    check("busy", 64'(io_busy), 64'(sz != 0));
    if (sz == 0) begin
      check("idle_way", 64'(io_sram_way_en), 64'(0));
      check("idle_addr", 64'(io_sram_addr), 64'(0));
      check("idle_wdata", io_sram_wdata, 64'(0));
    end
  end

  task automatic step(input logic v, input logic [7:0] w, input logic [11:0] a,
                      input logic [1:0] m, input logic [127:0] d, input logic rd);
    io_in_valid       = v;
    io_in_bits_way_en = w;
    io_in_bits_addr   = a;
    io_in_bits_wmask  = m;
    io_in_bits_data   = d;
    io_rd_valid       = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, 8'h0, 12'h0, 2'b00, 128'h0, rd);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_in_bits_way_en = '0;
    io_in_bits_addr = '0;
    io_in_bits_wmask = '0;
    io_in_bits_data = '0;
    io_rd_valid = 1'b0;
    idle(2, 1'b0);
    reset = 1'b0;
    idle(1, 1'b0);

    // Single full write.
    step(1'b1, 8'h04, 12'h123, 2'b11,
         {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b0);
    idle(3, 1'b0);

    // Single-half and empty masks.
    step(1'b1, 8'h10, 12'h0F0, 2'b10, rnd128(), 1'b0);
    idle(2, 1'b0);
    step(1'b1, 8'h01, 12'h055, 2'b00, rnd128(), 1'b0);
    idle(2, 1'b0);

    // Read priority between beats of a full write.
    step(1'b1, 8'h02, 12'h321, 2'b11, rnd128(), 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);

    // Backpressure: third request refused while reads hold the port.
    step(1'b1, 8'h01, 12'h001, 2'b11, rnd128(), 1'b1);
    step(1'b1, 8'h02, 12'h002, 2'b01, rnd128(), 1'b1);
    step(1'b1, 8'h04, 12'h003, 2'b10, rnd128(), 1'b1);
    idle(6, 1'b0);

    // Streaming single-half entries: enqueue and pop together, pointers wrap.
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'(1 << i), 12'(i * 17), 2'b01, rnd128(), 1'b0);
    idle(2, 1'b0);

    // Reset after beat 0 of a full write.
    step(1'b1, 8'h80, 12'hABC, 2'b11, rnd128(), 1'b0);
    idle(1, 1'b0);
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
    idle(2, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 2) != 0, 8'(1 << $urandom_range(0, 7)), 12'($urandom),
           2'($urandom), rnd128(), $urandom_range(0, 3) == 0);
    end
    reset = 1'b0;

    // Bounded drain.
    for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1, 1'b0);
    idle(1, 1'b0);
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_count", 64'(io_count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_write_sink.md
# data_write_sink

Receiving end of the data-cache data-array write arbitration path. It accepts arbitrated 128-bit write requests (way enable, row address, 2-bit half-word mask, data) through a valid/ready handshake and buffers them in a 2-entry FIFO. It drains each entry onto a single-ported, 64-bit-wide data SRAM write port, one 64-bit half per cycle. Array reads always take priority for the SRAM port, so pending writes stall while a read occupies it.

## Interface
Parameters: none (widths fixed by the data-array geometry).

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  1  write request valid
- io_in_ready  out  1  sink can accept a request this cycle
- io_in_bits_way_en  in  8  one-hot way select (passed through, not checked)
- io_in_bits_addr  in  12  data-array row address
- io_in_bits_wmask  in  2  bit0 = data[63:0] half, bit1 = data[127:64] half
- io_in_bits_data  in  128  write data
- io_rd_valid  in  1  array read owns the SRAM port this cycle; blocks writes
- io_sram_wen  out  1  SRAM write strobe
- io_sram_way_en  out  8  way enable of the head entry
- io_sram_addr  out  13  {row addr, half select}; half select is the LSB
- io_sram_wdata  out  64  selected 64-bit half of the head entry's data
- io_count  out  2  FIFO occupancy, 0..2
- io_busy  out  1  io_count != 0

## Operation
- **Storage:** 2-entry FIFO of {way_en, addr, wmask, data}, with a head pointer, a tail pointer and a 2-bit count. Pointers are 1 bit and wrap naturally.
- **Enqueue:** fires on io_in_valid & io_in_ready.
- **io_in_ready:** = (count != 2). It is computed from registered count only, so a same-cycle pop does not raise it.
- **Beat register:** `beat`, 1 bit, selects which half of the head entry is written next.
- **Beat selection when a beat starts:**
  - wmask=01: half 0 only.
  - wmask=10: half 1 only.
  - wmask=11: half 0, then half 1.
  - wmask=00: the entry is popped in one cycle with no write.
- **Drain step:** a cycle with count != 0 and !io_rd_valid.
  - wmask=11, beat=0: wen=1, half 0, beat <= 1, no pop.
  - wmask=11, beat=1: wen=1, half 1, pop, beat <= 0.
  - wmask=01 or 10: wen=1 on the single set half, pop.
  - wmask=00: wen=0, pop.
- **Stall:** io_rd_valid=1 forces io_sram_wen=0. Beat and pointers hold, and no pop occurs. Enqueue is still allowed.
- **Write outputs:**
  - io_sram_addr = {head.addr, half}.
  - io_sram_wdata = half ? head.data[127:64] : head.data[63:0].
  - way_en, addr and wdata are driven from the head entry whenever count != 0. They are 0 when empty.
- **Simultaneous enqueue and pop:** count holds, tail and head both advance.
- **Ordering:** strictly in order. No merging of writes to the same address.

## Timing
- **Reset values:** count=0, head=tail=0, beat=0, io_in_ready=1, io_sram_wen=0, io_busy=0, io_count=0, SRAM data/addr/way outputs 0.
- **Reset mid-operation:** all buffered entries and any half-completed beat are discarded. No write is issued in the reset cycle.
- **Latency:** a request accepted in cycle N gives its earliest io_sram_wen in cycle N+1, provided the FIFO was empty and io_rd_valid=0.
- **Output timing:** io_sram_wen, addr and wdata are combinational from registered head state and io_rd_valid. There is no combinational path from io_in_* to SRAM outputs.
- **Throughput:** one half-write per cycle. A wmask=11 entry occupies 2 unstalled cycles; all other entries occupy 1.
- **Full FIFO:** with count=2, io_in_ready=0 for at least one cycle even if a pop occurs that cycle.

## Test plan
- **Single full write:** reset, then enqueue way_en=0x04, addr=0x123, wmask=3, data={64'hAAAA…, 64'h5555…}.
  - cycle+1: wen=1, addr=0x246, wdata=0x5555…
  - cycle+2: wen=1, addr=0x247, wdata=0xAAAA…
  - then count=0.
- **Masks:** wmask=2 gives exactly one write at {addr,1} with the upper half. wmask=0 gives no wen, and count returns to 0 the next cycle.
- **Read priority:** hold io_rd_valid=1 for 3 cycles while a wmask=3 entry is between beats.
  - wen=0 throughout, beat held.
  - half 1 is written in the first cycle after the stall.
- **Full/backpressure:** enqueue 3 back-to-back requests with io_rd_valid=1.
  - third is refused: io_in_ready=0, io_count=2.
  - after release, writes drain in order with correct data.
- **Simultaneous enqueue/pop at count=1:** count stays 1, and head/tail wrap correctly across 4+ entries.
- **Reset mid-drain:** assert reset after beat 0 of a wmask=3 entry.
  - no half-1 write occurs.
  - outputs return to reset values the next cycle.
